// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: issues one multiply at a time to the Booth multiplier, short-circuiting
// zero operands, repeated operations and illegal codes, with timeout and enable-low release window.
module mult_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RELEASE_CYCLES = 2,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [11:0] req_codif,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rd,
    output logic        resp_err,
    output logic [1:0]  resp_src,
    output logic        mul_enable,
    output logic [31:0] mul_rs1,
    output logic [31:0] mul_rs2,
    output logic [11:0] mul_codif,
    input  logic [31:0] mul_rd,
    input  logic        mul_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES);

    state_e           state_q, state_d;
    logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [11:0]      cod_q, cod_d;
    logic             err_q, err_d;
    logic [1:0]       src_q, src_d;
    logic             c_valid_q, c_valid_d;
    logic [31:0]      c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_rd_q, c_rd_d;
    logic [11:0]      c_cod_q, c_cod_d;
    logic [CNT_W-1:0] rel_q, rel_d, to_q, to_d;
    logic             busy, accept, legal, zero, hit;

    assign busy       = state_q == ISSUE || state_q == WAIT;
    assign req_ready  = !reset && state_q == IDLE && rel_q == '0;
    assign accept     = req_valid && req_ready;
    assign legal      = req_codif inside {12'b010000110011, 12'b010010110011,
                                          12'b010100110011, 12'b010110110011};
    assign zero       = req_rs1 == '0 || req_rs2 == '0;
    assign hit        = c_valid_q && {c_rs1_q, c_rs2_q, c_cod_q} == {req_rs1, req_rs2, req_codif};
    assign resp_valid = state_q == RESP;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;
    assign resp_src   = src_q;
    assign mul_enable = busy;
    assign mul_rs1    = busy ? rs1_q : '0;
    assign mul_rs2    = busy ? rs2_q : '0;
    assign mul_codif  = busy ? cod_q : '0;

    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        cod_d     = cod_q;
        rd_d      = rd_q;
        err_d     = err_q;
        src_d     = src_q;
        rel_d     = rel_q == '0 ? '0 : rel_q - 1'b1;
        to_d      = to_q;
        c_valid_d = c_valid_q && !flush;
        c_rs1_d   = c_rs1_q;
        c_rs2_d   = c_rs2_q;
        c_cod_d   = c_cod_q;
        c_rd_d    = c_rd_q;
        case (state_q)
            IDLE: if (accept) begin
                rs1_d   = req_rs1;
                rs2_d   = req_rs2;
                cod_d   = req_codif;
                state_d = (!legal || zero || hit) ? RESP : ISSUE;
                err_d   = !legal;
                src_d   = !legal ? 2'd3 : zero ? 2'd1 : hit ? 2'd2 : 2'd0;
                rd_d    = (legal && !zero && hit) ? c_rd_q : '0;
            end
            ISSUE: begin
                state_d = WAIT;
                to_d    = '0;
            end
            WAIT: begin
                to_d = to_q + 1'b1;
                // Any exit drops enable and arms the release window so the Booth FSMs settle.
                if (mul_done) begin
                    state_d   = RESP;
                    rel_d     = REL_LOAD;
                    rd_d      = mul_rd;
                    err_d     = 1'b0;
                    src_d     = 2'd0;
                    c_valid_d = !flush;
                    c_rs1_d   = rs1_q;
                    c_rs2_d   = rs2_q;
                    c_cod_d   = cod_q;
                    c_rd_d    = mul_rd;
                end else if (to_q == TO_LAST) begin
                    state_d = RESP;
                    rel_d   = REL_LOAD;
                    rd_d    = '0;
                    err_d   = 1'b1;
                    src_d   = 2'd3;
                end
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            cod_q     <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            src_q     <= '0;
            rel_q     <= '0;
            to_q      <= '0;
            c_valid_q <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_cod_q   <= '0;
            c_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            cod_q     <= cod_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            src_q     <= src_d;
            rel_q     <= rel_d;
            to_q      <= to_d;
            c_valid_q <= c_valid_d;
            c_rs1_q   <= c_rs1_d;
            c_rs2_q   <= c_rs2_d;
            c_cod_q   <= c_cod_d;
            c_rd_q    <= c_rd_d;
        end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed and randomized requests against a transaction-level model
// of the sequencer, with a behavioural multiplier answering on the mul_* side.
module tb_mult_seq_ctrl;
    localparam logic [11:0] MUL    = 12'b010000110011;
    localparam logic [11:0] MULH   = 12'b010010110011;
    localparam logic [11:0] MULHSU = 12'b010100110011;
    localparam logic [11:0] MULHU  = 12'b010110110011;
    localparam int TIMEOUT = 64;
    localparam int RELEASE = 2;

    logic        clk, reset, flush, flush_a, req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_rs1, req_rs2, resp_rd, mul_rs1, mul_rs2, mul_rd;
    logic [11:0] req_codif, mul_codif;
    logic        resp_err, mul_enable, mul_done;
    logic [1:0]  resp_src;

    int checks = 0, fails = 0;
    int mdelay_g = -1, wait_cnt = 0, low_cnt = 0, en_seen = 0;
    logic had_op = 0, prev_en = 0, gap_bad = 0, hold_bad = 0, idle_bad = 0, mon_on = 0, fwd = 0;
    logic [31:0] cur_a, cur_b;
    logic [11:0] cur_c;
    logic        c_valid = 0;
    logic [31:0] c_a, c_b, c_rd;
    logic [11:0] c_c;

    assign flush = flush_a | (mul_done & fwd);

    mult_seq_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .RELEASE_CYCLES(RELEASE), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_codif(req_codif),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_err(resp_err), .resp_src(resp_src),
        .mul_enable(mul_enable), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_codif(mul_codif),
        .mul_rd(mul_rd), .mul_done(mul_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic legal(input logic [11:0] c);
        return c == MUL || c == MULH || c == MULHSU || c == MULHU;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [11:0] c);
        logic [63:0] ea, eb, p;
        ea = (c == MULH || c == MULHSU) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (c == MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (c == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_op();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'h0;
            1: r = 32'h3;
            2: r = 32'h5;
            3: r = 32'hFFFF_FFFF;
            4: r = 32'h8000_0000;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // Behavioural multiplier: answers mdelay_g cycles into an enable burst, and watches the sequencer's rules.
    initial begin
        mul_done = 0;
        mul_rd   = 0;
        forever begin
            @(negedge clk);
            mul_done = 0;
            if (mon_on && mul_enable) begin
                if (!prev_en && had_op && low_cnt < RELEASE) gap_bad = 1;
                had_op = 1;
                low_cnt = 0;
                en_seen++;
                if ({mul_rs1, mul_rs2, mul_codif} !== {cur_a, cur_b, cur_c}) hold_bad = 1;
                if (wait_cnt == mdelay_g) begin
                    mul_done = 1;
                    mul_rd = ref_mul(mul_rs1, mul_rs2, mul_codif);
                end
                wait_cnt++;
            end else if (mon_on) begin
                wait_cnt = 0;
                low_cnt++;
                if ({mul_rs1, mul_rs2, mul_codif} !== 76'h0) idle_bad = 1;
            end
            prev_en = mul_enable;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [11:0] c,
                          input int md, input int rw, input logic fl);
        logic [31:0] erd, srd;
        logic        eerr, serr, issued, stable;
        logic [1:0]  esrc, ssrc;
        int          n, elat;
        issued = 0;
        if (!legal(c)) begin
            erd = 0; eerr = 1; esrc = 3;
        end else if (a == 0 || b == 0) begin
            erd = 0; eerr = 0; esrc = 1;
        end else if (c_valid && c_a == a && c_b == b && c_c == c) begin
            erd = c_rd; eerr = 0; esrc = 2;
        end else if (md < 0) begin
            erd = 0; eerr = 1; esrc = 3; issued = 1;
        end else begin
            erd = ref_mul(a, b, c); eerr = 0; esrc = 0; issued = 1;
            c_valid = !fl; c_a = a; c_b = b; c_c = c; c_rd = erd;
        end
        elat = !issued ? 1 : (md < 0 ? TIMEOUT + 2 : md + 2);
        mdelay_g = md; fwd = fl; cur_a = a; cur_b = b; cur_c = c; en_seen = 0;
        req_valid = 1; req_rs1 = a; req_rs2 = b; req_codif = c;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        n = 1;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", resp_valid, 1);
        chk("latency", n, elat);
        chk("rd", resp_rd, erd);
        chk("err", resp_err, eerr);
        chk("src", resp_src, esrc);
        chk("en_used", en_seen > 0, issued);
        chk("en_low_resp", mul_enable, 0);
        srd = resp_rd; serr = resp_err; ssrc = resp_src; stable = 1;
        for (int i = 0; i < rw; i++) begin
            @(negedge clk);
            if (!resp_valid || req_ready || resp_rd !== srd || resp_err !== serr || resp_src !== ssrc) stable = 0;
        end
        if (rw > 0) chk("resp_hold", stable, 1);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        fwd = 0;
        chk("resp_drop", resp_valid, 0);
        chk("ready_after", req_ready, !(issued && rw == 0));
    endtask

    initial begin
        int n;
        reset = 1; flush_a = 0; req_valid = 0; resp_ready = 0;
        req_rs1 = 0; req_rs2 = 0; req_codif = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_src", resp_src, 0);
        chk("rst_mul_en", mul_enable, 0);
        chk("rst_mul_ops", {mul_rs1 | mul_rs2, 20'h0} | {20'h0, mul_codif}, 0);
        reset = 0;
        mon_on = 1;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);

        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU, 20, 0, 0);
        do_req(32'h0, 32'h1234, MUL, 5, 0, 0);
        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU, 20, 0, 0);
        @(negedge clk); flush_a = 1;
        @(negedge clk); flush_a = 0; c_valid = 0;
        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU, 7, 0, 0);
        do_req(32'h3, 32'h5, 12'h033, 5, 0, 0);
        do_req(32'h3, 32'h5, MUL, -1, 0, 0);
        do_req(32'h3, 32'h5, MUL, 3, 10, 0);
        do_req(32'h0, 32'h9, MULH, 3, 10, 0);
        do_req(32'h7, 32'h9, MULHSU, 3, 0, 1);
        do_req(32'h7, 32'h9, MULHSU, 4, 1, 0);
        do_req(32'h7, 32'h9, MULHSU, 4, 2, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a, b;
            logic [11:0] c;
            int md;
            a = pick_op(); b = pick_op();
            case ($urandom_range(0, 9))
                0: c = 12'($urandom);
                1, 2: c = MUL;
                3, 4: c = MULH;
                5, 6: c = MULHSU;
                default: c = MULHU;
            endcase
            md = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(1, 25));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); flush_a = 1;
                @(negedge clk); flush_a = 0; c_valid = 0;
            end
            do_req(a, b, c, md, int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        do_req(32'd11, 32'd13, MUL, 4, 0, 0);
        cur_a = 32'd17; cur_b = 32'd19; cur_c = MUL; mdelay_g = -1;
        req_valid = 1; req_rs1 = 32'd17; req_rs2 = 32'd19; req_codif = MUL;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        repeat (5) @(negedge clk);
        chk("mid_wait_en", mul_enable, 1);
        reset = 1;
        @(negedge clk);
        chk("mid_rst_en", mul_enable, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        reset = 0; c_valid = 0;
        repeat (3) @(negedge clk);
        do_req(32'd11, 32'd13, MUL, 4, 0, 0);

        chk("release_gap", gap_bad, 0);
        chk("inputs_held", hold_bad, 0);
        chk("inputs_zero_idle", idle_bad, 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencer between the core's execute stage and the Karatsuba/Booth multiplier unit. It accepts one multiply request at a time over a valid/ready handshake and latches the operands and the 12-bit function code. It drives the multiplier's enable and holds its inputs stable until the multiplier signals done, then forces an enable-low release window so the internal Booth FSMs return to idle. It short-circuits zero operands, repeated operations and illegal codes, applies a timeout, and returns the result over a valid/ready response port.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before aborting with an error.
RELEASE_CYCLES, 2, minimum cycles mul_enable stays low after any multiplier operation before the next issue (must be ≥1).
CNT_W, 7, width of the timeout and release counters (must satisfy 2^CNT_W > TIMEOUT_CYCLES).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  invalidates the result cache (single-cycle pulse)
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
req_codif  in  12  function code {funct7[6:0]... packed as the core decoder emits}
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_rd  out  32  result
resp_err  out  1  illegal code or timeout
resp_src  out  2  0=multiplier, 1=zero shortcut, 2=cache hit, 3=error
mul_enable  out  1  multiplier Enable
mul_rs1  out  32  multiplier rs1
mul_rs2  out  32  multiplier rs2
mul_codif  out  12  multiplier codif
mul_rd  in  32  multiplier result
mul_done  in  1  multiplier Done

Behaviour:
- Legal codes: MUL 12'b010000110011, MULH 12'b010010110011, MULHSU 12'b010100110011, MULHU 12'b010110110011.
- States: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE, req_ready=0 during reset, resp_valid=0, resp_rd=0, resp_err=0, resp_src=0, mul_enable=0, mul_rs1=0, mul_rs2=0, mul_codif=0, cache valid=0, release counter=0, timeout counter=0.
- req_ready=1 only in IDLE with release counter==0. A request is accepted when req_valid && req_ready; operands and code are latched at that edge.
- Decision at acceptance, in priority order:
  - Code illegal → RESP with err=1, rd=0, src=3.
  - rs1==0 or rs2==0 → RESP with rd=0, src=1.
  - Cache valid and {rs1,rs2,codif} match the cached entry → RESP with the cached rd, src=2.
  - Otherwise → ISSUE.
  - For all shortcut paths, resp_valid is asserted the cycle after acceptance.
- ISSUE: one cycle. mul_rs1/rs2/codif are driven with the latched values and mul_enable=1, then go to WAIT with the timeout counter cleared.
- WAIT: mul_enable=1 and inputs held. The timeout counter increments each cycle.
  - mul_done sampled high → capture mul_rd into resp_rd, src=0; write the cache (rs1, rs2, codif, rd, valid=1); go to RESP.
  - Else, counter reaches TIMEOUT_CYCLES-1 → RESP with err=1, rd=0, src=3; no cache write.
  - On either exit: mul_enable drops to 0 on the exit edge, and the release counter loads RELEASE_CYCLES.
- mul_rs1/rs2/codif are driven to 0 whenever state is not ISSUE or WAIT.
- Release counter decrements to 0 once per cycle in any state.
- RESP: resp_valid=1. resp_rd, resp_err and resp_src stay stable until resp_ready. On the handshake, go to IDLE and drop resp_valid that cycle. Back-to-back: the next request can be accepted in the cycle after the handshake, provided the release counter is 0.
- Latency:
  - Zero, cache hit or illegal code: accept at N, resp_valid at N+1.
  - Multiplier path: accept at N, mul_enable at N+1, response one cycle after mul_done is sampled.
- flush clears cache valid at the next edge. If flush coincides with a cache write, flush wins. flush does not abort an in-flight operation.
- reset mid-operation: state returns to IDLE immediately, mul_enable=0, and any pending response is discarded.
- mul_done outside WAIT is ignored.

Test Plan:
- MULHU 0xFFFFFFFF×0xFFFFFFFF, model mul_done after 20 cycles with rd=0xFFFFFFFE → resp_rd=0xFFFFFFFE, src=0, err=0; mul_enable low for ≥2 cycles before the next issue.
- MUL rs1=0, rs2=0x1234 → resp_valid 1 cycle after accept, rd=0, src=1, mul_enable never rises.
- Repeat the first request → 1-cycle response, rd=0xFFFFFFFE, src=2. Then pulse flush and repeat → multiplier path, src=0.
- codif=12'h033 → rd=0, err=1, src=3, no mul_enable.
- MUL 3×5 with mul_done never asserted → after 64 WAIT cycles: err=1, src=3, mul_enable=0, next request accepted only after the release window.
- Hold resp_ready=0 for 10 cycles → resp_valid and data stable, req_ready=0. Assert reset during WAIT → mul_enable=0 and resp_valid=0 next cycle.
